lab2_serial_sub: RTL and testbench



---
 rtl/lab2_pkg.sv | 16 +
 rtl/full_subtractor.sv | 23 ++
 rtl/lab2_serial_sub.sv | 125 ++++++++++++
 tb/tb_lab2_serial_sub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared definitions for the lab 2 serial arithmetic blocks.
//
// Contents:
//   DEFAULT_WIDTH : default operand width for the serial subtractor.
//   state_t       : FSM state encoding (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2).
package lab2_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor, the counterpart of the lab's full-adder cell.
// Computes a - b - bin for a single bit position.
//
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow from the less significant position
//   d    : difference bit
//   bout : borrow into the more significant position
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/lab2_serial_sub.sv
// Bit-serial subtractor: resolves D = (A - B - Bin) mod 2^WIDTH one bit per
// clock, LSB first, through a single full_subtractor cell. Bin/Bout allow
// several instances to be chained for wider words.
//
// Parameters:
//   WIDTH : operand and difference width (2..16)
//
// Ports:
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   Start : request, honoured only when the block can accept
//   A, B  : minuend / subtrahend, captured on the accepting edge
//   Bin   : borrow-in, captured on the accepting edge
//   Busy  : high from the accepting edge until the operation retires
//   Done  : one-cycle completion pulse
//   D     : difference, held until the next completion
//   Bout  : borrow-out, 1 iff A < B + Bin (unsigned)
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for Start
//   ST_SHIFT | one bit per clock through the subtractor cell
//   ST_DONE  | Done pulse cycle; a Start seen on the exit edge is accepted
//            | so back-to-back operations run every WIDTH+1 cycles
module lab2_serial_sub
  import lab2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;

  logic             d_bit;
  logic             bout_bit;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] rd_next;

  full_subtractor u_fs (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign rd_next  = {d_bit, rd[WIDTH-1:1]};
  // The DONE exit edge doubles as an accept edge so a held Start streams
  // operations with no idle gap.
  assign accept   = Start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      br    <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          Done <= 1'b0;
          if (accept) begin
            ra    <= A;
            rb    <= B;
            br    <= Bin;
            cnt   <= '0;
            rd    <= '0;
            Busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= rd_next;
          br  <= bout_bit;
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            D     <= rd_next;
            Bout  <= bout_bit;
            Done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_serial_sub.sv
module tb_lab2_serial_sub;

  localparam int W = 4;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] D;
  logic         Bout;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
  } vec_t;

  vec_t tbl[8];

  lab2_serial_sub #(.WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .D     (D),
    .Bout  (Bout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: 5-bit unsigned subtraction, bit 4 is the borrow.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic bin);
    logic [4:0] t;
    t = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    return t;
  endfunction

  // Waits edge by edge (sampling 1ns after) until Done; returns edge count.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (cyc < 20) begin
      @(posedge Clock); #1;
      cyc++;
      if (Busy) busy_cnt++;
      if (Done) break;
    end
    if (!Done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no Done within %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic bin, input logic [3:0] exp_d, input logic exp_bout);
    int cyc;
    int bc;
    @(negedge Clock);
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(posedge Clock); #1;
    check({name, " busy@accept"}, int'(Busy), 1);
    @(negedge Clock);
    Start = 1'b0;
    wait_done(cyc, bc);
    check({name, " latency"}, cyc, W);
    check({name, " D"}, int'(D), int'(exp_d));
    check({name, " Bout"}, int'(Bout), int'(exp_bout));
    @(posedge Clock); #1;
    check({name, " busy cycles"}, bc + 1, W + 1);
    check({name, " done pulse width"}, int'(Done), 0);
    check({name, " busy released"}, int'(Busy), 0);
  endtask

  initial begin
    int cyc;
    int bc;
    int stable;
    logic [8:0] k9;
    logic [4:0] m;
    logic [3:0] prev_d;

    n_vec = 0;
    n_err = 0;

    tbl[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, d: 4'd6,  bout: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, d: 4'd10, bout: 1'b1};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bout: 1'b1};
    tbl[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, d: 4'd0,  bout: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'd14, bout: 1'b0};
    tbl[5] = '{a: 4'd8,  b: 4'd8,  bin: 1'b1, d: 4'd15, bout: 1'b1};
    tbl[6] = '{a: 4'd7,  b: 4'd12, bin: 1'b1, d: 4'd10, bout: 1'b1};
    tbl[7] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bout: 1'b1};

    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset Busy", int'(Busy), 0);
    check("reset Done", int'(Done), 0);
    check("reset D", int'(D), 0);
    check("reset Bout", int'(Bout), 0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bout);

    // Exhaustive with Start held high: one accept every W+1 edges.
    @(negedge Clock);
    A = 4'd0; B = 4'd0; Bin = 1'b0; Start = 1'b1;
    @(posedge Clock); #1;
    check("exh first accept", int'(Busy), 1);
    prev_d = D;
    for (int k = 0; k < 512; k++) begin
      @(negedge Clock);
      if (k < 511) begin
        k9 = 9'(k + 1);
        A = k9[8:5]; B = k9[4:1]; Bin = k9[0];
      end else begin
        Start = 1'b0;
      end
      stable = 1;
      cyc = 0;
      while (cyc < 20) begin
        @(posedge Clock); #1;
        cyc++;
        if (Done) break;
        if (D != prev_d) stable = 0;
      end
      k9 = 9'(k);
      m = model(k9[8:5], k9[4:1], k9[0]);
      check($sformatf("exh%0d latency", k), cyc, W);
      check($sformatf("exh%0d D stable", k), stable, 1);
      check($sformatf("exh%0d D", k), int'(D), int'(m[3:0]));
      check($sformatf("exh%0d Bout", k), int'(Bout), int'(m[4]));
      prev_d = m[3:0];
      @(posedge Clock); #1;
      check($sformatf("exh%0d Done low", k), int'(Done), 0);
      check($sformatf("exh%0d re-accept Busy", k), int'(Busy), (k < 511) ? 1 : 0);
    end

    // Start toggling with new operands during SHIFT must be ignored.
    @(negedge Clock);
    A = 4'd10; B = 4'd3; Bin = 1'b1; Start = 1'b1;
    @(posedge Clock); #1;
    check("ign accept", int'(Busy), 1);
    for (int i = 0; i < W; i++) begin
      @(negedge Clock);
      Start = (i % 2 == 0) ? 1'b1 : 1'b0;
      A = 4'(i * 5 + 1); B = 4'(15 - i); Bin = 1'(i);
      @(posedge Clock); #1;
    end
    check("ign Done", int'(Done), 1);
    check("ign D", int'(D), 6);
    check("ign Bout", int'(Bout), 0);
    @(negedge Clock);
    Start = 1'b0;
    @(posedge Clock); #1;
    check("ign idle", int'(Busy), 0);

    // Reset on the 2nd SHIFT edge of 15-1.
    @(negedge Clock);
    A = 4'd15; B = 4'd1; Bin = 1'b0; Start = 1'b1;
    @(posedge Clock); #1;
    @(negedge Clock);
    Start = 1'b0;
    @(posedge Clock); #1;
    check("rst mid D held", int'(D), 6);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("rst mid Busy", int'(Busy), 0);
    check("rst mid Done", int'(Done), 0);
    check("rst mid D", int'(D), 0);
    check("rst mid Bout", int'(Bout), 0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (6) begin
      @(posedge Clock); #1;
      if (Done) check("rst mid stray Done", int'(Done), 0);
    end
    run_op("after rst", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0);

    // Reset and Start together: no accept; Start alone next edge accepts.
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b1; A = 4'd5; B = 4'd7; Bin = 1'b0;
    @(posedge Clock); #1;
    check("rst+start Busy", int'(Busy), 0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("start after rst Busy", int'(Busy), 1);
    @(negedge Clock);
    Start = 1'b0;
    wait_done(cyc, bc);
    check("start after rst latency", cyc, W);
    check("start after rst D", int'(D), 14);
    check("start after rst Bout", int'(Bout), 1);

    repeat (2) @(posedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
